// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit: N-step shift-add multiply or restoring
// divide over one shared N+1-bit adder, with a start/busy/done handshake.
module muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          mode;
  logic [N-1:0]  addend;
  logic [N-1:0]  divisor;
  logic [CW-1:0] count;

  logic [N:0]    x;
  logic [N:0]    y;
  logic          sub;
  logic [N:0]    sum;

  // Shared adder/subtractor; the divide path keeps the bit shifted out of hi so
  // divisors at or above 2^(N-1) still compare correctly.
  always_comb begin
    x   = {(N+1){1'b0}};
    y   = {(N+1){1'b0}};
    sub = 1'b0;
    if (mode) begin
      x   = {hi, lo[N-1]};
      y   = {1'b0, divisor};
      sub = 1'b1;
    end else begin
      x   = {1'b0, hi};
      sub = 1'b0;
      if (lo[0]) begin
        y = {1'b0, addend};
      end else begin
        y = {(N+1){1'b0}};
      end
    end
    sum = x + (sub ? ~y : y) + {{N{1'b0}}, sub};
  end

  // Sequencer state, working registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= 1'b0;
      addend      <= {N{1'b0}};
      divisor     <= {N{1'b0}};
      count       <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      lo          <= {N{1'b0}};
      hi          <= {N{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode    <= op;
            addend  <= a;
            divisor <= b;
            count   <= {CW{1'b0}};
            busy    <= 1'b1;
            if (op && (b == {N{1'b0}})) begin
              state       <= DONE;
              lo          <= {N{1'b1}};
              hi          <= a;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              hi          <= {N{1'b0}};
              lo          <= op ? a : b;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          count <= count + CW'(1);
          if (mode) begin
            if (!sum[N]) begin
              hi <= sum[N-1:0];
              lo <= {lo[N-2:0], 1'b1};
            end else begin
              hi <= {hi[N-2:0], lo[N-1]};
              lo <= {lo[N-2:0], 1'b0};
            end
          end else begin
            hi <= sum[N:1];
            lo <= {sum[0], lo[N-1:1]};
          end
          if (count == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // A divide-by-zero enters with done low and raises it one cycle later.
          if (done) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (N = 32) with hand-computed results.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_by_zero;

  int passed = 0;
  int total  = 0;

  int          r_lat;
  int          r_busy;
  int          r_done;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_dbz;

  muldiv_seq #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation; r_lat = number of edges from the accept edge to the
  // edge that first samples done high. inj > 0 pulses a competing start then.
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int inj);
    r_lat = 0; r_busy = 0; r_done = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (busy) r_busy++;
      if (done) begin
        r_done++;
        if (r_lat == 0) begin
          r_lat = i; r_lo = lo; r_hi = hi; r_dbz = div_by_zero;
        end
      end
      if (i == inj) begin
        start = 1'b1; op = ~o; a = 32'd1000; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (r_lat != 0 && !busy) break;
    end
  endtask

  initial begin
    int d1, d2, d3, nd;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_lo", lo, 0);
    check("reset_hi", hi, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 32'd7, 32'd6, 0);
    check("mul7x6_lat", r_lat, 33);
    check("mul7x6_busy_cycles", r_busy, 33);
    check("mul7x6_done_pulses", r_done, 1);
    check("mul7x6_lo", r_lo, 32'd42);
    check("mul7x6_hi", r_hi, 32'd0);

    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mul_max_hi", r_hi, 32'hFFFF_FFFE);
    check("mul_max_lo", r_lo, 32'h0000_0001);

    do_op(1'b0, 32'h8000_0000, 32'd2, 0);
    check("mul_msb_hi", r_hi, 32'd1);
    check("mul_msb_lo", r_lo, 32'd0);

    do_op(1'b1, 32'd100, 32'd7, 0);
    check("div100_7_lat", r_lat, 33);
    check("div100_7_q", r_lo, 32'd14);
    check("div100_7_r", r_hi, 32'd2);
    check("div100_7_dbz", r_dbz, 0);

    do_op(1'b1, 32'd5, 32'd9, 0);
    check("div5_9_q", r_lo, 32'd0);
    check("div5_9_r", r_hi, 32'd5);

    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    check("div_bigdiv_q", r_lo, 32'd1);
    check("div_bigdiv_r", r_hi, 32'h7FFF_FFFE);

    do_op(1'b1, 32'd5, 32'd0, 0);
    check("div0_lat", r_lat, 2);
    check("div0_busy_cycles", r_busy, 2);
    check("div0_lo", r_lo, 32'hFFFF_FFFF);
    check("div0_hi", r_hi, 32'd5);
    check("div0_flag", r_dbz, 1);
    check("div0_flag_held", div_by_zero, 1);

    do_op(1'b1, 32'd100, 32'd7, 0);
    check("div0_flag_cleared", r_dbz, 0);
    check("div_after_div0_q", r_lo, 32'd14);

    // Competing start during RUN must be ignored.
    do_op(1'b0, 32'd11, 32'd13, 5);
    check("ign_run_lat", r_lat, 33);
    check("ign_run_lo", r_lo, 32'd143);
    check("ign_run_hi", r_hi, 32'd0);

    // Competing start during DONE must be ignored; then IDLE holds the result.
    do_op(1'b0, 32'd12, 32'd12, 33);
    check("ign_done_lo", r_lo, 32'd144);
    repeat (5) @(negedge clk);
    check("idle_no_busy", busy, 0);
    check("idle_lo_stable", lo, 32'd144);
    check("idle_hi_stable", hi, 32'd0);

    // start held high: completions every N+2 = 34 cycles.
    d1 = 0; d2 = 0; d3 = 0; nd = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = i;
        else if (nd == 2) d2 = i;
        else if (nd == 3) d3 = i;
        check("b2b_lo", lo, 32'd15);
      end
      if (nd == 3) break;
    end
    start = 1'b0;
    check("b2b_gap1", d2 - d1, 34);
    check("b2b_gap2", d3 - d2, 34);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("b2b_drained", busy, 0);

    // Asynchronous reset at step 10 of a multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd123; b = 32'd456;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("rst_no_done", nd, 0);

    do_op(1'b0, 32'd3, 32'd3, 0);
    check("post_rst_lat", r_lat, 33);
    check("post_rst_lo", r_lo, 32'd9);
    check("post_rst_hi", r_hi, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
